// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, NOP word and PC step.
package fetch_stage_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t StIdle  = 2'd0;
    localparam fetch_state_t StRun   = 2'd1;
    localparam fetch_state_t StPause = 2'd2;

    localparam logic [31:0] NopInstr    = 32'h0000_0000;
    localparam logic [31:0] PcInc       = 32'd4;
    localparam logic [31:0] PcAlignMask = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating event counter with synchronous clear; sticks at all-ones.
module fetch_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect handling and IF/ID pipeline register.
// Optional performance counters are compiled in with FETCH_PERF_CNT_EN.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_target_i,
    input  logic             jump_i,
    input  logic [31:0]      jump_target_i,
    output logic [31:0]      imem_addr_o,
    input  logic [31:0]      imem_data_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      ifid_pc4_o,
    output logic [31:0]      ifid_instr_o,
`ifdef FETCH_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
`endif
    output logic             ifid_valid_o
);

    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    fetch_state_t state_d, state_q;
    logic [31:0]  pc_d, pc_q;
    logic [31:0]  ifid_pc4_d, ifid_pc4_q;
    logic [31:0]  ifid_instr_d, ifid_instr_q;
    logic         ifid_valid_d, ifid_valid_q;
    logic         stall_evt, flush_evt;
    logic [31:0]  pc_plus4;

    assign pc_plus4 = pc_q + PcInc;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        stall_evt    = 1'b0;
        flush_evt    = 1'b0;

        case (state_q)
            StRun: begin
                stall_evt = stall_i;
                if (!start_i) begin
                    // Pausing wins over any redirect presented in the same cycle.
                    state_d      = StPause;
                    ifid_instr_d = NopInstr;
                    ifid_valid_d = 1'b0;
                end else if (stall_i) begin
                    // Hold everything.
                end else if (jump_i) begin
                    pc_d         = jump_target_i & PcAlignMask;
                    ifid_instr_d = NopInstr;
                    ifid_valid_d = 1'b0;
                    flush_evt    = 1'b1;
                end else if (branch_taken_i) begin
                    pc_d         = branch_target_i & PcAlignMask;
                    ifid_instr_d = NopInstr;
                    ifid_valid_d = 1'b0;
                    flush_evt    = 1'b1;
                end else begin
                    pc_d         = pc_plus4;
                    ifid_pc4_d   = pc_plus4;
                    ifid_instr_d = imem_data_i;
                    ifid_valid_d = 1'b1;
                end
            end
            default: begin
                // Idle and pause: PC holds, IF/ID drains to a bubble.
                if (start_i) begin
                    state_d = StRun;
                end
                if (state_q != StIdle && state_q != StPause) begin
                    state_d = StIdle;
                end
                ifid_instr_d = NopInstr;
                ifid_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            ifid_pc4_q   <= 32'h0;
            ifid_instr_q <= NopInstr;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign pc_o         = pc_q;
    assign imem_addr_o  = pc_q;
    assign ifid_pc4_o   = ifid_pc4_q;
    assign ifid_instr_o = ifid_instr_q;
    assign ifid_valid_o = ifid_valid_q;

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .clr_i (~rst_i),
        .inc_i (stall_evt),
        .cnt_o (stall_cnt_o)
    );

    fetch_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk_i (clk_i),
        .clr_i (~rst_i),
        .inc_i (flush_evt),
        .cnt_o (flush_cnt_o)
    );
`else
    logic unused_evt;
    assign unused_evt = stall_evt ^ flush_evt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table plus stall/flush saturation sequences.
module tb_fetch_stage;

    localparam int unsigned CntW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start, stall, br, jump;
    logic [31:0]     btgt, jtgt;
    logic [31:0]     imem_addr, imem_data;
    logic [31:0]     pc, pc4, instr;
    logic            valid;
    logic [CntW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instruction memory model: a few fixed words, otherwise address + 0x1000_0000.
    always_comb begin
        case (imem_addr)
            32'h0:   imem_data = 32'h11;
            32'h4:   imem_data = 32'h22;
            32'h8:   imem_data = 32'h33;
            32'hC:   imem_data = 32'h44;
            default: imem_data = imem_addr + 32'h1000_0000;
        endcase
    end

    fetch_stage #(
        .RESET_PC (32'h0),
        .CNT_W    (CntW)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_n),
        .start_i         (start),
        .stall_i         (stall),
        .branch_taken_i  (br),
        .branch_target_i (btgt),
        .jump_i          (jump),
        .jump_target_i   (jtgt),
        .imem_addr_o     (imem_addr),
        .imem_data_i     (imem_data),
        .pc_o            (pc),
        .ifid_pc4_o      (pc4),
        .ifid_instr_o    (instr),
`ifdef FETCH_PERF_CNT_EN
        .stall_cnt_o     (stall_cnt),
        .flush_cnt_o     (flush_cnt),
`endif
        .ifid_valid_o    (valid)
    );

`ifndef FETCH_PERF_CNT_EN
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        stall;
        logic        jump;
        logic [31:0] jtgt;
        logic        br;
        logic [31:0] btgt;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic [31:0] e_instr;
        logic        e_valid;
        int          e_scnt;
        int          e_fcnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_cnts(input string tag, input int scnt, input int fcnt);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'(scnt));
        chk({tag, " flush_cnt"}, 32'(flush_cnt), 32'(fcnt));
`else
        if (scnt < 0 || fcnt < 0) $display("note: negative count in %s", tag);
`endif
    endtask

    task automatic drive(input logic r, input logic s, input logic st, input logic j,
                         input logic [31:0] jt, input logic b, input logic [31:0] bt);
        rst_n = r; start = s; stall = st; jump = j; jtgt = jt; br = b; btgt = bt;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic r, logic s, logic st, logic j, logic [31:0] jt,
                                logic b, logic [31:0] bt, logic [31:0] epc,
                                logic [31:0] epc4, logic [31:0] ein, logic ev,
                                int es, int ef);
        vec_t v;
        v = '{r, s, st, j, jt, b, bt, epc, epc4, ein, ev, es, ef};
        return v;
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; jump = 1'b0; br = 1'b0;
        jtgt = '0; btgt = '0;

        //                 rst s  st j  jtgt           b  btgt      pc            pc4       instr          v  sc fc
        vecs.push_back(mk(0, 1, 0, 1, 32'h40,        0, 32'h0,   32'h0,        32'h0,  32'h0,         0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,         0, 32'h0,   32'h0,        32'h0,  32'h0,         0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,         0, 32'h0,   32'h0,        32'h0,  32'h0,         0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,         0, 32'h0,   32'h4,        32'h4,  32'h11,        1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,         0, 32'h0,   32'h8,        32'h8,  32'h22,        1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 32'h0,         0, 32'h0,   32'h8,        32'h8,  32'h22,        1, 1, 0));
        vecs.push_back(mk(1, 1, 1, 0, 32'h0,         1, 32'h20,  32'h8,        32'h8,  32'h22,        1, 2, 0));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,         0, 32'h0,   32'hC,        32'hC,  32'h33,        1, 2, 0));
        vecs.push_back(mk(1, 1, 0, 1, 32'h40,        1, 32'h80,  32'h40,       32'hC,  32'h0,         0, 2, 1));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,         0, 32'h0,   32'h44,       32'h44, 32'h1000_0040, 1, 2, 1));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,         1, 32'h23,  32'h20,       32'h44, 32'h0,         0, 2, 2));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,         0, 32'h0,   32'h24,       32'h24, 32'h1000_0020, 1, 2, 2));
        vecs.push_back(mk(1, 1, 0, 1, 32'h7F,        0, 32'h0,   32'h7C,       32'h24, 32'h0,         0, 2, 3));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,         1, 32'h100, 32'h7C,       32'h24, 32'h0,         0, 2, 3));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,         0, 32'h0,   32'h7C,       32'h24, 32'h0,         0, 2, 3));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,         0, 32'h0,   32'h7C,       32'h24, 32'h0,         0, 2, 3));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,         0, 32'h0,   32'h80,       32'h80, 32'h1000_007C, 1, 2, 3));
        vecs.push_back(mk(1, 1, 1, 0, 32'h0,         0, 32'h0,   32'h80,       32'h80, 32'h1000_007C, 1, 3, 3));
        vecs.push_back(mk(0, 1, 1, 1, 32'h40,        1, 32'h80,  32'h0,        32'h0,  32'h0,         0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,         0, 32'h0,   32'h0,        32'h0,  32'h0,         0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,         0, 32'h0,   32'h4,        32'h4,  32'h11,        1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 32'hFFFF_FFFF, 0, 32'h0,   32'hFFFF_FFFC, 32'h4, 32'h0,         0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,         0, 32'h0,   32'h0,        32'h0,  32'h0FFF_FFFC, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,         0, 32'h0,   32'h4,        32'h4,  32'h11,        1, 0, 1));

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].rst_n, vecs[i].start, vecs[i].stall, vecs[i].jump, vecs[i].jtgt,
                  vecs[i].br, vecs[i].btgt);
            chk({tag, " pc"}, pc, vecs[i].e_pc);
            chk({tag, " imem_addr"}, imem_addr, vecs[i].e_pc);
            chk({tag, " pc4"}, pc4, vecs[i].e_pc4);
            chk({tag, " instr"}, instr, vecs[i].e_instr);
            chk({tag, " valid"}, 32'(valid), 32'(vecs[i].e_valid));
            chk_cnts(tag, vecs[i].e_scnt, vecs[i].e_fcnt);
        end

        // Long stall at pc=4: everything frozen, stall counter saturates at 7.
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 1, 0, 32'h0, 1, 32'h200);
            chk($sformatf("stall%0d pc", i), pc, 32'h4);
            chk($sformatf("stall%0d instr", i), instr, 32'h11);
        end
        chk_cnts("stall_sat", 7, 1);

        // Repeated jumps: flush counter saturates at 7.
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 0, 1, 32'h8, 0, 32'h0);
            chk($sformatf("jump%0d pc", i), pc, 32'h8);
            chk($sformatf("jump%0d valid", i), 32'(valid), 32'h0);
        end
        chk_cnts("flush_sat", 7, 7);

        drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
        chk("resume pc", pc, 32'hC);
        chk("resume instr", instr, 32'h33);
        chk("resume valid", 32'(valid), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
